// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with wrap, saturate and one-shot modes.
// Supports an enable prescaler, clamped load and a registered carry pulse.
module mod_updown_counter #(
   parameter int N  = 6,
   parameter int PS = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         ld,
   input  logic [N-1:0] ld_val,
   input  logic         dir,
   input  logic [1:0]   mode,
   input  logic [N-1:0] limit,
   output logic [N-1:0] out,
   output logic         tc,
   output logic         co,
   output logic         done
);

   localparam int PW = (PS > 1) ? $clog2(PS) : 1;
   localparam logic [PW-1:0] PTOP = PW'(PS - 1);

   typedef enum logic {RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [PW-1:0] pcnt, pcnt_nx;
   logic [N-1:0]  out_nx;
   logic          co_nx;
   logic          term;

   assign tc   = dir ? (out == limit) : (out == '0);
   assign done = (state == DONE);

   // an up step from above limit is handled as terminal
   assign term = dir ? (out >= limit) : (out == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         pcnt  <= '0;
         out   <= '0;
         co    <= 1'b0;
      end else begin
         state <= state_nx;
         pcnt  <= pcnt_nx;
         out   <= out_nx;
         co    <= co_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pcnt_nx  = pcnt;
      out_nx   = out;
      co_nx    = 1'b0;
      if (clr) begin
         out_nx   = '0;
         pcnt_nx  = '0;
         state_nx = RUN;
      end else if (ld) begin
         out_nx   = (ld_val > limit) ? limit : ld_val;
         pcnt_nx  = '0;
         state_nx = RUN;
      end else if (state == RUN && en) begin
         if (pcnt != PTOP) begin
            pcnt_nx = pcnt + 1'b1;
         end else begin
            pcnt_nx = '0;
            if (!term) begin
               out_nx = dir ? out + 1'b1 : out - 1'b1;
            end else begin
               co_nx = 1'b1;
               case (mode)
                  2'b01:   out_nx = out;
                  2'b10:   state_nx = DONE;
                  default: out_nx = dir ? '0 : limit;
               endcase
            end
         end
      end
   end

endmodule
